// File: rtl/apb_m_if_if.sv
// rtl/apb_m_if_if.sv - command/response and APB3 bus bundle for the apb_m_if requester.
interface apb_m_if_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;

  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;

  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;

  // master: the requester; slave: the local controller plus the APB completer
  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    output psel, penable, pwrite, paddr, pwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    input  psel, penable, pwrite, paddr, pwdata
  );
endinterface

// File: rtl/apb_m_if.sv
// rtl/apb_m_if.sv - APB3 requester: one command at a time through IDLE/SETUP/ACCESS,
// returning read data or a timeout abort on a single-cycle response pulse.
module apb_m_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic       pclk,
  input  logic       presetn,
  apb_m_if_if.master bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10
  } state_e;

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LIMIT   = CW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  state_e                state_q;
  logic                  psel_q;
  logic                  penable_q;
  logic                  pwrite_q;
  logic [ADDR_WIDTH-1:0] paddr_q;
  logic [DATA_WIDTH-1:0] pwdata_q;
  logic                  rsp_valid_q;
  logic                  rsp_err_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic [CW-1:0]         cnt_q;
  logic                  limit_hit;

  // Abort on the edge where the wait count would reach TIMEOUT; pready wins on that edge.
  assign limit_hit = (TIMEOUT != 0) && (cnt_q == (LIMIT - CW'(1)));

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q     <= IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      cnt_q       <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.cmd_valid) begin
            paddr_q   <= bus.cmd_addr;
            pwrite_q  <= bus.cmd_write;
            pwdata_q  <= bus.cmd_write ? bus.cmd_wdata : '0;
            psel_q    <= 1'b1;
            penable_q <= 1'b0;
            state_q   <= SETUP;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          cnt_q     <= '0;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          if (bus.pready) begin
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            if (!pwrite_q) begin
              rsp_rdata_q <= bus.prdata;
            end
            state_q     <= IDLE;
          end else if (limit_hit) begin
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_rdata_q <= '0;
            cnt_q       <= LIMIT;
            state_q     <= IDLE;
          end else if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.psel      = psel_q;
  assign bus.penable   = penable_q;
  assign bus.pwrite    = pwrite_q;
  assign bus.paddr     = paddr_q;
  assign bus.pwdata    = pwdata_q;

endmodule

// File: tb/tb_apb_m_if.sv
// tb/tb_apb_m_if.sv - bench for apb_m_if: directed scenarios then random transfers
// against a transaction-level memory/latency model.
module tb_apb_m_if;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic pclk = 1'b0;
  logic presetn = 1'b0;
  always #5 pclk = ~pclk;

  apb_m_if_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  apb_m_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .pclk    (pclk),
    .presetn (presetn),
    .bus     (bus)
  );

  int tests_run = 0;
  int tests_failed = 0;

  // ref_mem: what a correct requester must have written; cmp_mem: what the completer saw on APB
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] cmp_mem [logic [31:0]];
  logic [31:0] last_rdata;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] fill(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  // Entered and left just after a falling edge; the command is accepted on the next rising edge.
  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input int waits, input string tag);
    logic [31:0] rd_val;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_lat;
    int          lat;
    bit          done;
    rd_val  = cmp_mem.exists(a) ? cmp_mem[a] : fill(a);
    exp_err = (waits >= TO);
    exp_lat = exp_err ? TO + 2 : waits + 3;
    if (exp_err)  exp_rd = 32'h0;
    else if (!w)  exp_rd = ref_mem.exists(a) ? ref_mem[a] : fill(a);
    else          exp_rd = last_rdata;

    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    bus.pready    = 1'b0;
    check($sformatf("%s.cmd_ready", tag), bus.cmd_ready, 1);
    lat  = 0;
    done = 0;
    while (!done && lat < 40) begin
      @(negedge pclk);
      lat++;
      if (lat == 1) begin
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = $urandom;
        bus.cmd_wdata = $urandom;
      end
      if (bus.rsp_valid) begin
        done = 1;
      end else if (lat == 1) begin
        check($sformatf("%s.setup_ctl", tag), {bus.psel, bus.penable}, 2'b10);
        check($sformatf("%s.paddr", tag), bus.paddr, a);
        check($sformatf("%s.pwrite", tag), bus.pwrite, w);
        check($sformatf("%s.pwdata", tag), bus.pwdata, w ? d : 32'h0);
      end else begin
        check($sformatf("%s.access_ctl", tag), {bus.psel, bus.penable}, 2'b11);
        check($sformatf("%s.paddr_stable", tag), bus.paddr, a);
        check($sformatf("%s.pwdata_stable", tag), bus.pwdata, w ? d : 32'h0);
        if (lat - 1 > waits) begin
          bus.pready = 1'b1;
          bus.prdata = rd_val;
          if (bus.pwrite) cmp_mem[bus.paddr] = bus.pwdata;
        end else begin
          bus.pready = 1'b0;
          bus.prdata = $urandom;
        end
      end
    end
    check($sformatf("%s.rsp_seen", tag), done, 1);
    check($sformatf("%s.latency", tag), lat, exp_lat);
    check($sformatf("%s.rsp_err", tag), bus.rsp_err, exp_err);
    check($sformatf("%s.rsp_rdata", tag), bus.rsp_rdata, exp_rd);
    check($sformatf("%s.idle_ctl", tag), {bus.psel, bus.penable}, 2'b00);
    bus.pready = 1'b0;
    if (!exp_err && w) ref_mem[a] = d;
    last_rdata = exp_rd;
  endtask

  logic [5:0] psel_v;
  logic [5:0] rv_v;

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.prdata    = '0;
    bus.pready    = 1'b0;
    last_rdata    = 32'h0;
    repeat (2) @(negedge pclk);
    check("reset.ctl", {bus.psel, bus.penable, bus.pwrite, bus.rsp_valid, bus.rsp_err}, 5'b0);
    check("reset.paddr", bus.paddr, 0);
    check("reset.pwdata", bus.pwdata, 0);
    check("reset.rsp_rdata", bus.rsp_rdata, 0);
    check("reset.cmd_ready", bus.cmd_ready, 1);
    presetn = 1'b1;
    @(negedge pclk);

    xfer(1'b1, 32'h10, 32'hDEADBEEF, 0, "t1_write");
    cmp_mem[32'h20] = 32'h12345678;
    ref_mem[32'h20] = 32'h12345678;
    xfer(1'b0, 32'h20, 32'hFFFF_FFFF, 0, "t2_read");
    xfer(1'b0, 32'h10, 32'h0, 3, "t3_wait_read");
    xfer(1'b0, 32'h30, 32'h0, 9, "t4_rd_timeout");
    xfer(1'b1, 32'h10, 32'h1111, TO, "t4_wr_timeout");
    xfer(1'b0, 32'h10, 32'h0, TO - 1, "t4_limit_edge");

    // Held cmd_valid: the second write must be taken in the first response cycle.
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 32'h40;
    bus.cmd_wdata = 32'hA1;
    bus.pready    = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge pclk);
      psel_v[c-1] = bus.psel;
      rv_v[c-1]   = bus.rsp_valid;
      if (bus.psel && bus.penable && bus.pwrite) cmp_mem[bus.paddr] = bus.pwdata;
      if (c == 3) begin
        check("t5.cmd_ready", bus.cmd_ready, 1);
        bus.cmd_addr  = 32'h44;
        bus.cmd_wdata = 32'hB2;
      end
      if (c == 4) begin
        bus.cmd_valid = 1'b0;
        check("t5.paddr2", bus.paddr, 32'h44);
        check("t5.pwdata2", bus.pwdata, 32'hB2);
      end
    end
    bus.pready = 1'b0;
    check("t5.psel_pattern", psel_v, 6'b011011);
    check("t5.rsp_pattern", rv_v, 6'b100100);
    ref_mem[32'h40] = 32'hA1;
    ref_mem[32'h44] = 32'hB2;

    // Reset during ACCESS drops the bus at once and loses the command.
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 32'h44;
    @(negedge pclk);
    bus.cmd_valid = 1'b0;
    @(negedge pclk);
    check("t6.in_access", {bus.psel, bus.penable}, 2'b11);
    presetn = 1'b0;
    #1;
    check("t6.rst_ctl", {bus.psel, bus.penable, bus.rsp_valid}, 3'b000);
    check("t6.rst_ready", bus.cmd_ready, 1);
    repeat (2) @(negedge pclk);
    presetn = 1'b1;
    last_rdata = 32'h0;
    for (int c = 0; c < 3; c++) begin
      @(negedge pclk);
      check("t6.no_rsp", {bus.rsp_valid, bus.psel}, 2'b00);
    end
    check("t6.rsp_rdata_cleared", bus.rsp_rdata, 0);
    xfer(1'b0, 32'h44, 32'h0, 1, "t6_after_reset");

    for (int i = 0; i < 40; i++) begin
      logic        w;
      logic [31:0] a;
      w = 1'($urandom_range(0, 1));
      a = 32'h100 + 32'(4 * $urandom_range(0, 7));
      xfer(w, a, $urandom, int'($urandom_range(0, 5)), $sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
